// File: rtl/fpu_pkg.sv
// Shared definitions for the float-to-int converter: FSM states and
// IEEE-754 binary32 / int32 boundary constants.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } ftoi_state_e;

    localparam logic [7:0]  EXP_BIAS     = 8'd127;
    localparam logic [7:0]  EXP_INT_BASE = 8'd150;
    localparam logic [4:0]  SHIFT_CLAMP  = 5'd26;
    localparam logic [31:0] INT32_MAX    = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN    = 32'h8000_0000;

    // Smallest biased exponent whose magnitude is at least 2^31.
    localparam logic [7:0]  EXP_SAT      = EXP_BIAS + 8'd31;

endpackage

// File: rtl/ftoi_decode.sv
// Combinational classifier for a binary32 operand: detects saturating
// inputs and works out the shift direction and distance for normal ones.
module ftoi_decode
    import fpu_pkg::*;
(
    input  logic [31:0] a_i,
    output logic        special_o,
    output logic [31:0] sp_res_o,
    output logic        sp_ovf_o,
    output logic        left_o,
    output logic [4:0]  k_o
);

    logic [7:0] exp_s;
    logic [7:0] diff_s;
    logic       frac_nz_s;

    assign exp_s     = a_i[30:23];
    assign frac_nz_s = (a_i[22:0] != 23'd0);

    // Classify the operand and derive the shift distance.
    always_comb begin
        special_o = 1'b0;
        sp_res_o  = 32'd0;
        sp_ovf_o  = 1'b0;
        left_o    = 1'b0;
        k_o       = 5'd0;
        diff_s    = 8'd0;
        if (exp_s == 8'hFF && frac_nz_s) begin
            special_o = 1'b1;
            sp_res_o  = INT32_MAX;
            sp_ovf_o  = 1'b1;
        end else if (exp_s >= EXP_SAT) begin
            special_o = 1'b1;
            // -2^31 is the one value at this magnitude that int32 can hold.
            if (a_i == 32'hCF00_0000) begin
                sp_res_o = INT32_MIN;
                sp_ovf_o = 1'b0;
            end else begin
                sp_res_o = a_i[31] ? INT32_MIN : INT32_MAX;
                sp_ovf_o = 1'b1;
            end
        end else if (exp_s >= EXP_INT_BASE) begin
            left_o = 1'b1;
            diff_s = exp_s - EXP_INT_BASE;
            k_o    = diff_s[4:0];
        end else begin
            left_o = 1'b0;
            diff_s = EXP_INT_BASE - exp_s;
            k_o    = (diff_s > {3'd0, SHIFT_CLAMP}) ? SHIFT_CLAMP : diff_s[4:0];
        end
    end

endmodule

// File: rtl/ftoi_seq.sv
// Sequential binary32 -> int32 converter: one-bit-per-cycle shifter followed
// by round-to-nearest-even, with a valid/ready handshake on both sides.
module ftoi_seq
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic        ovf
);

    ftoi_state_e state_q, state_d;
    logic [4:0]  k_q, k_d;
    logic [30:0] mag_q, mag_d;
    logic        guard_q, guard_d;
    logic        sticky_q, sticky_d;
    logic        sign_q, sign_d;
    logic        left_q, left_d;
    logic [31:0] res_q, res_d;
    logic        ovf_q, ovf_d;
    logic        out_valid_q, out_valid_d;

    logic        dec_special_s;
    logic [31:0] dec_res_s;
    logic        dec_ovf_s;
    logic        dec_left_s;
    logic [4:0]  dec_k_s;
    logic        round_up_s;
    logic [31:0] mag_rnd_s;

    ftoi_decode u_decode (
        .a_i       (a),
        .special_o (dec_special_s),
        .sp_res_o  (dec_res_s),
        .sp_ovf_o  (dec_ovf_s),
        .left_o    (dec_left_s),
        .k_o       (dec_k_s)
    );

    assign round_up_s = guard_q & (sticky_q | mag_q[0]);
    assign mag_rnd_s  = {1'b0, mag_q} + {31'd0, round_up_s};

    // Next-state and datapath logic for the conversion FSM.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        mag_d       = mag_q;
        guard_d     = guard_q;
        sticky_d    = sticky_q;
        sign_d      = sign_q;
        left_d      = left_q;
        res_d       = res_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = a[31];
                    if (dec_special_s) begin
                        res_d       = dec_res_s;
                        ovf_d       = dec_ovf_s;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        mag_d    = {7'd0, (a[30:23] != 8'd0), a[22:0]};
                        guard_d  = 1'b0;
                        sticky_d = 1'b0;
                        left_d   = dec_left_s;
                        k_d      = dec_k_s;
                        state_d  = (dec_k_s != 5'd0) ? SHIFT : ROUND;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (left_q) begin
                    mag_d = {mag_q[29:0], 1'b0};
                end else begin
                    mag_d    = {1'b0, mag_q[30:1]};
                    guard_d  = mag_q[0];
                    sticky_d = sticky_q | guard_q;
                end
                k_d     = k_q - 5'd1;
                state_d = (k_q == 5'd1) ? ROUND : SHIFT;
            end
            ROUND: begin
                // Two's-complement negate of zero is zero, so no negative zero.
                res_d       = sign_q ? (32'd0 - mag_rnd_s) : mag_rnd_s;
                ovf_d       = 1'b0;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= 5'd0;
            mag_q       <= 31'd0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            sign_q      <= 1'b0;
            left_q      <= 1'b0;
            res_q       <= 32'd0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            mag_q       <= mag_d;
            guard_q     <= guard_d;
            sticky_q    <= sticky_d;
            sign_q      <= sign_d;
            left_q      <= left_d;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign ovf       = ovf_q;

endmodule
